elastic_buffer: RTL and testbench
=================================

ELASTIC_BUFFER -- requirements
Module: elastic_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default from param.v, payload width in bits.
REQ-002 Parameter DEPTH, default 2, number of storage entries; SHALL be a power of two and >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 input_data  input  DATA_WIDTH  upstream payload.
REQ-006 valid_input  input  1  upstream payload valid.
REQ-007 stop_input  output  1  backpressure to upstream.
REQ-008 output_data  output  DATA_WIDTH  payload to downstream fork.
REQ-009 valid_output  output  1  downstream payload valid.
REQ-010 stop_output  input  1  backpressure from downstream fork.
REQ-011 occupancy  output  $clog2(DEPTH)+1  current entry count.

Function
REQ-012 Enqueue SHALL occur in a cycle with valid_input=1 and stop_input=0; dequeue SHALL occur in a cycle with valid_output=1 and stop_output=0.
REQ-013 Storage SHALL be a circular array with write and read pointers, each wrapping from DEPTH-1 to 0.
REQ-014 occupancy SHALL increment on enqueue-only, decrement on dequeue-only, and stay unchanged on simultaneous enqueue and dequeue or on neither.
REQ-015 stop_input SHALL be a function of registered state only: 1 when occupancy==DEPTH, else 0; a dequeue in the same cycle SHALL NOT release it.
REQ-016 Without bypass, valid_output SHALL be 1 exactly when occupancy!=0, and output_data SHALL equal the entry at the read pointer.
REQ-017 output_data SHALL be all zeros whenever valid_output=0.
REQ-018 While valid_output=1 and stop_output=1, output_data and valid_output SHALL hold stable into the next cycle.
REQ-019 Items SHALL leave in exact arrival order; none dropped or duplicated.
REQ-020 Without bypass, minimum latency SHALL be 1 cycle: an item enqueued at edge N is presented after edge N.
REQ-021 Full throughput SHALL be sustained at one item per cycle when stop_output stays 0.
REQ-022 stop_output SHALL be sampled only while valid_output=1; its value while valid_output=0 has no effect.

Reset
REQ-023 On a rising edge with reset_n=0, occupancy and both pointers SHALL clear to 0; storage contents are not cleared.
REQ-024 While reset_n=0, stop_input SHALL be forced 1, valid_output forced 0, and output_data forced 0, combinationally.
REQ-025 A reset during operation SHALL discard all stored items; the first cycle after release SHALL show occupancy=0, stop_input=0, valid_output=0.

Configuration
REQ-026 Macro ELASTIC_BUFFER_BYPASS_EN SHALL control empty-buffer bypass.
REQ-027 With ELASTIC_BUFFER_BYPASS_EN defined and occupancy==0, valid_output SHALL equal valid_input and output_data SHALL equal input_data combinationally (zero latency).
REQ-028 With bypass active, valid_input=1 and stop_output=0, the item SHALL pass through without being written, and occupancy SHALL stay 0.
REQ-029 With bypass active, valid_input=1 and stop_output=1, the item SHALL be written and occupancy SHALL become 1.
REQ-030 Without ELASTIC_BUFFER_BYPASS_EN, no combinational path SHALL exist from input_data or valid_input to any output; behaviour follows REQ-016 and REQ-020.
REQ-031 stop_input SHALL obey REQ-015 in both configurations.

Verification (DATA_WIDTH=32, DEPTH=2, no bypass unless stated)
REQ-032 Reset, then 1 idle cycle -> occupancy=0, valid_output=0, output_data=0, stop_input=0.
REQ-033 Hold stop_output=1; enqueue 0xA1, then 0xB2 -> occupancy=2, stop_input=1; 0xC3 with valid_input=1 not accepted; release stop_output -> outputs 0xA1, 0xB2, then 0xC3.
REQ-034 stop_output=0; stream 0x00..0x0F one per cycle -> 16 consecutive outputs in order, each 1 cycle after input; occupancy never exceeds 1.
REQ-035 Full buffer; dequeue and valid_input=1 in the same cycle -> no enqueue that cycle (stop_input=1); occupancy=1 next cycle.
REQ-036 Occupancy=2, pointers wrapped; drive reset_n=0 for 1 edge -> next cycle occupancy=0, valid_output=0; stale data never emitted.
REQ-037 ELASTIC_BUFFER_BYPASS_EN defined, empty, stop_output=0; input 0x55 -> output_data=0x55, valid_output=1 same cycle; occupancy stays 0.

Source files
------------

// File: rtl/elastic_buffer.sv
// elastic_buffer: circular-array elastic buffer; define ELASTIC_BUFFER_BYPASS_EN for zero-latency empty bypass
module elastic_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   input_data,
  input  logic                    valid_input,
  output logic                    stop_input,
  output logic [DATA_WIDTH-1:0]   output_data,
  output logic                    valid_output,
  input  logic                    stop_output,
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_full;
  logic                  w_valid;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_pass;
  logic [DATA_WIDTH-1:0] w_data;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("elastic_buffer: DEPTH must be a power of two and >= 2");
  end

  // Backpressure depends only on registered occupancy, so a same-cycle dequeue never frees a slot.
  assign w_full     = r_count == CW'(DEPTH);
  assign stop_input = !reset_n || w_full;

`ifdef ELASTIC_BUFFER_BYPASS_EN
  logic w_empty;
  assign w_empty = r_count == '0;
  // When empty, the upstream item is presented directly; it is stored only if downstream stalls it.
  assign w_valid = reset_n && (w_empty ? valid_input : 1'b1);
  assign w_data  = w_empty ? input_data : r_mem[r_rd_ptr];
  assign w_pass  = w_empty && valid_input && !stop_output;
`else
  assign w_valid = reset_n && r_count != '0;
  assign w_data  = r_mem[r_rd_ptr];
  assign w_pass  = 1'b0;
`endif

  assign valid_output = w_valid;
  assign output_data  = w_valid ? w_data : '0;
  assign occupancy    = r_count;
  assign w_enq        = valid_input && !stop_input;
  assign w_deq        = w_valid && !stop_output;
  assign w_wr         = w_enq && !w_pass;
  assign w_rd         = w_deq && !w_pass;

  // Storage is not reset; stale entries are unreachable once occupancy clears.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= input_data;
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks net enqueue/dequeue.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr <= w_rd ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_count  <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
endmodule

// File: tb/tb_elastic_buffer.sv
// tb_elastic_buffer: directed self-checking bench for elastic_buffer (DATA_WIDTH=32, DEPTH=2)
module tb_elastic_buffer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] input_data;
  logic        valid_input;
  logic        stop_input;
  logic [31:0] output_data;
  logic        valid_output;
  logic        stop_output;
  logic [1:0]  occupancy;
  int          n_checks = 0;
  int          n_errors = 0;

  elastic_buffer #(.DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .input_data   (input_data),
    .valid_input  (valid_input),
    .stop_input   (stop_input),
    .output_data  (output_data),
    .valid_output (valid_output),
    .stop_output  (stop_output),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    valid_input = 1'b0;
    stop_output = 1'b0;
    input_data  = '0;
    #1;
    chk("rst_stop_in", 32'(stop_input), 1);
    chk("rst_valid", 32'(valid_output), 0);
    chk("rst_data", output_data, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("idle_occ", 32'(occupancy), 0);
    chk("idle_valid", 32'(valid_output), 0);
    chk("idle_data", output_data, 0);
    chk("idle_stop_in", 32'(stop_input), 0);

    stop_output = 1'b1;
    valid_input = 1'b1;
    input_data  = 32'hA1;
    step();
    input_data = 32'hB2;
    step();
    input_data = 32'hC3;
    chk("full_occ", 32'(occupancy), 2);
    chk("full_stop_in", 32'(stop_input), 1);
    chk("full_head", output_data, 32'hA1);
    step();
    chk("stall_occ", 32'(occupancy), 2);
    chk("stall_hold_valid", 32'(valid_output), 1);
    chk("stall_hold_data", output_data, 32'hA1);
    stop_output = 1'b0;
    step();
    chk("deq_full_occ", 32'(occupancy), 1);
    chk("deq_full_data", output_data, 32'hB2);
    chk("deq_full_stop_in", 32'(stop_input), 0);
    step();
    valid_input = 1'b0;
    chk("c3_occ", 32'(occupancy), 1);
    chk("c3_data", output_data, 32'hC3);
    step();
    chk("drain_occ", 32'(occupancy), 0);
    chk("drain_valid", 32'(valid_output), 0);
    chk("drain_data", output_data, 0);

`ifdef ELASTIC_BUFFER_BYPASS_EN
    stop_output = 1'b0;
    valid_input = 1'b1;
    input_data  = 32'h55;
    #1;
    chk("byp_valid", 32'(valid_output), 1);
    chk("byp_data", output_data, 32'h55);
    step();
    valid_input = 1'b0;
    #1;
    chk("byp_occ", 32'(occupancy), 0);
    chk("byp_idle_valid", 32'(valid_output), 0);
`else
    stop_output = 1'b1;
    #1;
    chk("empty_stop_out_ignored", 32'(valid_output), 0);
    stop_output = 1'b0;
    for (int i = 0; i < 16; i++) begin
      valid_input = 1'b1;
      input_data  = 32'(i);
      #1;
      chk("no_comb_path", 32'(valid_output), i == 0 ? 0 : 1);
      step();
      chk("stream_valid", 32'(valid_output), 1);
      chk("stream_data", output_data, 32'(i));
      chk("stream_occ", 32'(occupancy), 1);
    end
    valid_input = 1'b0;
    step();
    chk("stream_end_occ", 32'(occupancy), 0);
    chk("stream_end_valid", 32'(valid_output), 0);

    stop_output = 1'b1;
    valid_input = 1'b1;
    input_data  = 32'h11;
    step();
    input_data = 32'h22;
    step();
    chk("pre_rst_occ", 32'(occupancy), 2);
    chk("pre_rst_head", output_data, 32'h11);
    input_data = 32'h33;
    reset_n    = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_output), 0);
    chk("mid_rst_data", output_data, 0);
    chk("mid_rst_stop_in", 32'(stop_input), 1);
    step();
    reset_n     = 1'b1;
    valid_input = 1'b0;
    stop_output = 1'b0;
    #1;
    chk("post_rst_occ", 32'(occupancy), 0);
    chk("post_rst_valid", 32'(valid_output), 0);
    chk("post_rst_data", output_data, 0);
    chk("post_rst_stop_in", 32'(stop_input), 0);
    step();
    chk("no_stale_valid", 32'(valid_output), 0);
    valid_input = 1'b1;
    input_data  = 32'h44;
    step();
    valid_input = 1'b0;
    chk("post_rst_item", output_data, 32'h44);
    chk("post_rst_item_occ", 32'(occupancy), 1);
    step();
    chk("final_occ", 32'(occupancy), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
